// File: rtl/keccak_absorb_packer.sv
// Packs a little-endian byte stream into Keccak rate-sized blocks.
// Applies the SHA-3/SHAKE domain byte and the final 0x80 pad, then offers each block downstream.
module keccak_absorb_packer #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [1:0]                  mode_select,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_last,
    input  logic [$clog2(DATA_W/8):0]   in_bytes,
    output logic                        blk_valid,
    input  logic                        blk_ready,
    output logic [1343:0]               blk_data,
    output logic                        blk_last,
    output logic [1:0]                  blk_mode,
    output logic [CNT_W-1:0]            blk_idx,
    output logic                        busy,
    output logic                        done
);

    localparam int BW   = DATA_W / 8;
    localparam int NB_W = $clog2(BW) + 1;
    localparam int MAXR = 168;

    typedef enum logic [1:0] {IDLE, FILL, PAD, OUT} state_t;

    state_t              state;
    logic [7:0]          ptr;
    logic [7:0]          rate;
    logic [7:0]          ds;
    logic                pad_pending;
    logic [8*MAXR-1:0]   blk_buf;
    logic [8*MAXR-1:0]   padded;
    logic [NB_W-1:0]     n_last;
    logic [7:0]          start_rate;
    logic [7:0]          start_ds;

    always_comb begin
        start_rate = 8'd168;
        start_ds   = 8'h1F;
        case (mode_select)
            2'b00: begin start_rate = 8'd168; start_ds = 8'h1F; end
            2'b01: begin start_rate = 8'd136; start_ds = 8'h1F; end
            2'b10: begin start_rate = 8'd136; start_ds = 8'h06; end
            default: begin start_rate = 8'd72; start_ds = 8'h06; end
        endcase
    end

    assign n_last = (in_bytes > NB_W'(BW)) ? NB_W'(BW) : in_bytes;

    // Domain byte and final pad bit XOR independently, so ptr == rate-1 yields ds|0x80.
    always_comb begin
        padded = blk_buf;
        for (int j = 0; j < MAXR; j++) begin
            padded[8*j +: 8] = blk_buf[8*j +: 8]
                             ^ ((8'(j) == ptr)         ? ds    : 8'h00)
                             ^ ((8'(j) == rate - 8'd1) ? 8'h80 : 8'h00);
        end
    end

    assign blk_data = blk_buf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            rate        <= '0;
            ds          <= '0;
            pad_pending <= 1'b0;
            blk_buf     <= '0;
            in_ready    <= 1'b0;
            blk_valid   <= 1'b0;
            blk_last    <= 1'b0;
            blk_mode    <= '0;
            blk_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rate        <= start_rate;
                        ds          <= start_ds;
                        blk_mode    <= mode_select;
                        blk_buf     <= '0;
                        ptr         <= '0;
                        blk_idx     <= '0;
                        pad_pending <= 1'b0;
                        blk_last    <= 1'b0;
                        busy        <= 1'b1;
                        in_ready    <= 1'b1;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        if (!in_last) begin
                            for (int i = 0; i < BW; i++)
                                blk_buf[8*(int'(ptr)+i) +: 8] <= in_data[8*i +: 8];
                            ptr <= ptr + 8'(BW);
                            if (ptr + 8'(BW) == rate) begin
                                in_ready  <= 1'b0;
                                blk_valid <= 1'b1;
                                blk_last  <= 1'b0;
                                state     <= OUT;
                            end
                        end else begin
                            // Bytes past n_last are left at their cleared value.
                            for (int i = 0; i < BW; i++)
                                if (i < int'(n_last))
                                    blk_buf[8*(int'(ptr)+i) +: 8] <= in_data[8*i +: 8];
                            ptr      <= ptr + 8'(n_last);
                            in_ready <= 1'b0;
                            state    <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (ptr == rate) begin
                        pad_pending <= 1'b1;
                        blk_last    <= 1'b0;
                    end else begin
                        blk_buf     <= padded;
                        pad_pending <= 1'b0;
                        blk_last    <= 1'b1;
                    end
                    blk_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (blk_ready) begin
                        blk_buf   <= '0;
                        ptr       <= '0;
                        blk_idx   <= blk_idx + 1'b1;
                        blk_valid <= 1'b0;
                        if (blk_last) begin
                            blk_last <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else if (pad_pending) begin
                            state <= PAD;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= FILL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_absorb_packer.sv
// Directed bench for keccak_absorb_packer: builds expected padded blocks from the
// FIPS-202 rate/domain tables and checks contents, handshakes, latency and reset.
module tb_keccak_absorb_packer;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;
    localparam int BW     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        mode_select;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [3:0]        in_bytes;
    logic              blk_valid;
    logic              blk_ready;
    logic [1343:0]     blk_data;
    logic              blk_last;
    logic [1:0]        blk_mode;
    logic [CNT_W-1:0]  blk_idx;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;
    logic [7:0] expBlk [168];

    keccak_absorb_packer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode_select(mode_select),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .in_bytes(in_bytes), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .blk_last(blk_last), .blk_mode(blk_mode),
        .blk_idx(blk_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int rateOf(input int m);
        case (m)
            0: return 168;
            1: return 136;
            2: return 136;
            default: return 72;
        endcase
    endfunction

    function automatic logic [7:0] dsOf(input int m);
        return (m < 2) ? 8'h1F : 8'h06;
    endfunction

    // Message byte k is simply k mod 256.
    task automatic buildExpected(input int mode, input int len, input int b);
        int r, nf, tail;
        r  = rateOf(mode);
        nf = len / r;
        for (int j = 0; j < 168; j++) expBlk[j] = 8'h00;
        if (b < nf) begin
            for (int j = 0; j < r; j++) expBlk[j] = 8'((b * r + j) % 256);
        end else begin
            tail = len - nf * r;
            for (int j = 0; j < tail; j++) expBlk[j] = 8'((nf * r + j) % 256);
            expBlk[tail]  = expBlk[tail] ^ dsOf(mode);
            expBlk[r - 1] = expBlk[r - 1] ^ 8'h80;
        end
    endtask

    task automatic checkBlock(input string tag);
        logic [63:0] e;
        for (int c = 0; c < 21; c++) begin
            for (int i = 0; i < 8; i++) e[8*i +: 8] = expBlk[8*c + i];
            checkOutput($sformatf("%s chunk%0d", tag, c), blk_data[64*c +: 64], e);
        end
    endtask

    task automatic applyStimulus(input int mode, input int len, input int stall, input bit noise);
        int nw, r, nf, nblk, widx, bidx, stallCnt, cyc, hsCycle, expectLat, sent;
        bit sawValid;
        logic [1343:0] snap;
        r    = rateOf(mode);
        nw   = (len == 0) ? 1 : (len + 7) / 8;
        nf   = len / r;
        nblk = nf + 1;
        widx = 0; bidx = 0; stallCnt = 0; cyc = 0; hsCycle = 0; expectLat = 0;
        sawValid = 1'b0;
        snap = '0;

        @(negedge clk);
        start = 1'b1;
        mode_select = 2'(mode);
        @(negedge clk);
        start = 1'b0;
        checkOutput($sformatf("m%0d busy after start", mode), 64'(busy), 64'd1);
        checkOutput($sformatf("m%0d in_ready in FILL", mode), 64'(in_ready), 64'd1);

        while (bidx < nblk && cyc < 3000) begin
            if (noise) begin
                start = (widx < nw);
                mode_select = ~2'(mode);
            end
            blk_ready = 1'b0;
            if (blk_valid) begin
                if (!sawValid) begin
                    sawValid = 1'b1;
                    snap = blk_data;
                    buildExpected(mode, len, bidx);
                    if (expectLat != 0) begin
                        checkOutput($sformatf("len%0d blk%0d latency", len, bidx),
                                    64'(cyc - hsCycle), 64'(expectLat));
                        expectLat = 0;
                    end
                end
                if (stallCnt < stall) begin
                    checkOutput("in_ready low in OUT", 64'(in_ready), 64'd0);
                    checkOutput("blk_data stable", 64'(blk_data == snap), 64'd1);
                    stallCnt++;
                end else begin
                    checkBlock($sformatf("len%0d blk%0d", len, bidx));
                    checkOutput($sformatf("len%0d blk%0d last", len, bidx), 64'(blk_last), 64'(bidx == nf));
                    checkOutput($sformatf("len%0d blk%0d idx", len, bidx), 64'(blk_idx), 64'(bidx));
                    checkOutput($sformatf("len%0d blk%0d mode", len, bidx), 64'(blk_mode), 64'(mode));
                    blk_ready = 1'b1;
                    bidx++;
                    stallCnt = 0;
                    sawValid = 1'b0;
                end
            end
            if (widx < nw) begin
                in_valid = 1'b1;
                in_last  = (widx == nw - 1);
                for (int i = 0; i < BW; i++)
                    in_data[8*i +: 8] = (widx * 8 + i < len) ? 8'((widx * 8 + i) % 256) : 8'hA5;
                in_bytes = in_last ? 4'(len - 8 * widx) : 4'd3;
                if (in_ready) begin
                    hsCycle = cyc;
                    sent = (len < (widx + 1) * 8) ? len : (widx + 1) * 8;
                    if (in_last) expectLat = 2;
                    else if (sent % r == 0) expectLat = 1;
                    widx++;
                end
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end

        blk_ready = 1'b0;
        in_valid  = 1'b0;
        start     = 1'b0;
        if (bidx == nblk) begin
            checkOutput($sformatf("len%0d done pulse", len), 64'(done), 64'd1);
            checkOutput($sformatf("len%0d busy cleared", len), 64'(busy), 64'd0);
            checkOutput($sformatf("len%0d blk_valid cleared", len), 64'(blk_valid), 64'd0);
            @(negedge clk);
            checkOutput($sformatf("len%0d done one cycle", len), 64'(done), 64'd0);
        end else begin
            checkOutput($sformatf("len%0d timeout", len), 64'd0, 64'd1);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd0);
        checkOutput({tag, " blk_valid"}, 64'(blk_valid), 64'd0);
        checkOutput({tag, " busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " done"}, 64'(done), 64'd0);
        checkOutput({tag, " blk_last"}, 64'(blk_last), 64'd0);
        checkOutput({tag, " blk_mode"}, 64'(blk_mode), 64'd0);
        checkOutput({tag, " blk_idx"}, 64'(blk_idx), 64'd0);
        checkOutput({tag, " blk_data zero"}, 64'(blk_data == '0), 64'd1);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        mode_select = 2'b00;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        in_bytes = '0;
        blk_ready = 1'b0;
        #22;
        checkResetState("reset");
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(0, 32, 0, 1'b0);
        applyStimulus(1, 135, 0, 1'b0);
        applyStimulus(1, 136, 0, 1'b0);
        applyStimulus(3, 0, 0, 1'b0);
        applyStimulus(0, 200, 10, 1'b1);

        // Abort a SHA3-256 message mid-fill, then rerun the first message.
        @(negedge clk);
        start = 1'b1;
        mode_select = 2'b10;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_last = 1'b0;
        in_data = 64'h0706050403020100;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 checkResetState("midfill reset");
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 32, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
